// File: rtl/inv_key_sched.sv
// Inverse AES-128 key schedule: walks round keys 10 down to 0, one per handshake.
// Also holds the combinational AES S-box used for SubWord.

module s_box (
    input  logic [7:0] data_in,
    output logic [7:0] data_out
);
    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    assign data_out = SBOX[data_in];
endmodule

module inv_key_sched (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [127:0] key_in,
    input  logic         rk_ready,
    output logic         rk_valid,
    output logic [127:0] rk_out,
    output logic [3:0]   rk_round,
    output logic         busy,
    output logic         done
);
    localparam int unsigned KEY_W   = 128;
    localparam int unsigned WORD_W  = 32;
    localparam int unsigned ROUND_W = 4;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_OUT  = 1'b1;

    logic [0:0]         state_q, state_d;
    logic [KEY_W-1:0]   key_q, key_d;
    logic [ROUND_W-1:0] round_q, round_d;
    logic               done_q, done_d;

    logic [WORD_W-1:0] w0, w1, w2, w3;
    logic [WORD_W-1:0] p0, p1, p2, p3;
    logic [WORD_W-1:0] rot_w, sub_w;
    logic [7:0]        rcon;
    logic [KEY_W-1:0]  prev_key;

    assign {w0, w1, w2, w3} = key_q;
    assign p3    = w3 ^ w2;
    assign p2    = w2 ^ w1;
    assign p1    = w1 ^ w0;
    assign rot_w = {p3[23:0], p3[31:24]};

    for (genvar b = 0; b < 4; b++) begin : g_sub
        s_box u_s_box (
            .data_in  (rot_w[8*b +: 8]),
            .data_out (sub_w[8*b +: 8])
        );
    end

    // Rcon indexed by the round of the key currently held.
    always_comb begin
        rcon = 8'h00;
        case (round_q)
            4'd10:   rcon = 8'h36;
            4'd9:    rcon = 8'h1b;
            4'd8:    rcon = 8'h80;
            4'd7:    rcon = 8'h40;
            4'd6:    rcon = 8'h20;
            4'd5:    rcon = 8'h10;
            4'd4:    rcon = 8'h08;
            4'd3:    rcon = 8'h04;
            4'd2:    rcon = 8'h02;
            4'd1:    rcon = 8'h01;
            default: rcon = 8'h00;
        endcase
    end

    assign p0       = w0 ^ sub_w ^ {rcon, 24'h0};
    assign prev_key = {p0, p1, p2, p3};

    always_comb begin
        state_d = state_q;
        key_d   = key_q;
        round_d = round_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_OUT;
                    key_d   = key_in;
                    round_d = ROUND_W'(10);
                end
            end
            ST_OUT: begin
                if (rk_ready) begin
                    if (round_q == '0) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        key_d   = prev_key;
                        round_d = round_q - ROUND_W'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            key_q   <= '0;
            round_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            key_q   <= key_d;
            round_q <= round_d;
            done_q  <= done_d;
        end
    end

    assign rk_valid = (state_q == ST_OUT);
    assign busy     = (state_q != ST_IDLE);
    assign rk_out   = key_q;
    assign rk_round = round_q;
    assign done     = done_q;
endmodule

// File: tb/tb_inv_key_sched.sv
// Scoreboard bench for inv_key_sched using FIPS-197 A.1 and C.1 key vectors.

module tb_inv_key_sched;
    logic         clk;
    logic         rst;
    logic         start;
    logic [127:0] key_in;
    logic         rk_ready;
    logic         rk_valid;
    logic [127:0] rk_out;
    logic [3:0]   rk_round;
    logic         busy;
    logic         done;

    typedef struct {
        logic [3:0]   rnd;
        logic [127:0] key;
        bit           chk;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;
    bit   exp_done = 0;

    logic [127:0] a1 [11];
    localparam logic [127:0] C1_R10 = 128'h13111d7fe3944a17f307a78b4d2b30c5;
    localparam logic [127:0] C1_R0  = 128'h000102030405060708090a0b0c0d0e0f;

    inv_key_sched dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .key_in   (key_in),
        .rk_ready (rk_ready),
        .rk_valid (rk_valid),
        .rk_out   (rk_out),
        .rk_round (rk_round),
        .busy     (busy),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push_a1();
        for (int r = 10; r >= 0; r--) sb_q.push_back('{rnd: 4'(r), key: a1[r], chk: 1'b1});
    endtask

    // Only the endpoints of the C.1 schedule are known here; middle rounds check the index only.
    task automatic push_c1();
        for (int r = 10; r >= 0; r--)
            sb_q.push_back('{rnd: 4'(r), key: (r == 10) ? C1_R10 : (r == 0) ? C1_R0 : 128'h0,
                             chk: (r == 10 || r == 0)});
    endtask

    task automatic do_start(input logic [127:0] k);
        key_in = k;
        start  = 1'b1;
        @(posedge clk); #1;
        start  = 1'b0;
    endtask

    task automatic wait_done(input bit random_ready);
        int n = 0;
        while (!done && n < 400) begin
            @(posedge clk); #1;
            if (random_ready) rk_ready = 1'($urandom_range(0, 1));
            n++;
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL wait_done: got timeout expected done pulse");
        end
        rk_ready = 1'b1;
    endtask

    task automatic wait_round(input logic [3:0] r);
        int n = 0;
        while (!(rk_valid && rk_round == r) && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (!(rk_valid && rk_round == r)) begin
            errors++;
            $display("FAIL wait_round: got timeout expected round %0d", r);
        end
    endtask

    // Monitor: compares DUT output against the head of the scoreboard queue.
    always @(negedge clk) begin
        if (!rst) begin
            if (exp_done) begin
                check("done_pulse", 128'(done), 128'(1));
                check("done_busy", 128'(busy), 128'(0));
                check("done_valid", 128'(rk_valid), 128'(0));
                exp_done = 0;
            end else if (done) begin
                check("done_spurious", 128'(done), 128'(0));
            end
            if (rk_valid) begin
                check("valid_busy", 128'(busy), 128'(1));
                if (sb_q.size() == 0) begin
                    check("unexpected_valid", 128'(rk_valid), 128'(0));
                end else begin
                    check("rk_round", 128'(rk_round), 128'(sb_q[0].rnd));
                    if (sb_q[0].chk) check(rk_ready ? "rk_out" : "rk_out_hold", rk_out, sb_q[0].key);
                    if (rk_ready) begin
                        if (sb_q[0].rnd == 4'd0) exp_done = 1;
                        void'(sb_q.pop_front());
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        a1[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
        a1[9]  = 128'hac7766f319fadc2128d12941575c006e;
        a1[8]  = 128'head27321b58dbad2312bf5607f8d292f;
        a1[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
        a1[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
        a1[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
        a1[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
        a1[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
        a1[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
        a1[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
        a1[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;

        rst = 1'b0; start = 1'b0; rk_ready = 1'b0; key_in = '0;
        #1 rst = 1'b1;
        #1;
        check("reset_valid", 128'(rk_valid), 128'(0));
        check("reset_busy",  128'(busy),     128'(0));
        check("reset_done",  128'(done),     128'(0));
        check("reset_rk_out", rk_out,        128'h0);
        check("reset_round", 128'(rk_round), 128'(0));
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // Full walk with the consumer always ready.
        rk_ready = 1'b1;
        push_a1();
        do_start(a1[10]);
        wait_done(1'b0);
        repeat (3) @(posedge clk);
        #1;
        check("idle_after_walk", 128'(rk_valid), 128'(0));
        check("queue_drained", 128'(sb_q.size()), 128'(0));

        // Backpressure, starting stalled on round 10.
        rk_ready = 1'b0;
        push_a1();
        do_start(a1[10]);
        wait_done(1'b1);
        @(posedge clk); #1;

        // Start while busy must be ignored.
        push_a1();
        do_start(a1[10]);
        wait_round(4'd5);
        key_in = C1_R10;
        start  = 1'b1;
        @(posedge clk); #1;
        start  = 1'b0;
        wait_done(1'b0);
        @(posedge clk); #1;

        // Asynchronous reset mid-sequence.
        push_a1();
        do_start(a1[10]);
        wait_round(4'd4);
        rst = 1'b1;
        #1;
        check("midrst_valid", 128'(rk_valid), 128'(0));
        check("midrst_busy",  128'(busy),     128'(0));
        check("midrst_rk_out", rk_out,        128'h0);
        check("midrst_round", 128'(rk_round), 128'(0));
        sb_q.delete();
        exp_done = 0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        push_c1();
        do_start(C1_R10);
        wait_done(1'b0);

        // Back-to-back: start issued in the done cycle.
        @(posedge clk); #1;
        push_a1();
        do_start(a1[10]);
        wait_done(1'b0);
        push_c1();
        do_start(C1_R10);
        wait_done(1'b0);
        repeat (3) @(posedge clk);
        #1;
        check("final_idle", 128'(busy), 128'(0));
        check("final_queue", 128'(sb_q.size()), 128'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
